// File: rtl/ofifo_pkg.sv
// Shared widths for the MAC-array output path and pointer sizing for the lane FIFOs.
package ofifo_pkg;
  localparam int COL = 8;
  localparam int PSUM_BW = 16;

  // One extra MSB beyond the address distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ofifo_if.sv
// Data/strobe bundle between the array bottom row, the ofifo and the downstream accumulator.
interface ofifo_if import ofifo_pkg::*; #(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW
);
  logic [col*psum_bw-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*psum_bw-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_overflow;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready, o_overflow
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready, o_overflow
  );
endinterface

// File: rtl/ofifo_fifo_lane.sv
// Single-column circular buffer; head data is presented combinationally for the row register above.
module fifo_lane import ofifo_pkg::*; #(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [psum_bw-1:0] in,
  output logic [psum_bw-1:0] out,
  output logic               empty,
  output logic               full
);
  localparam int PW = ptr_w(depth);
  localparam int AW = PW - 1;

  logic [psum_bw-1:0] mem_q [depth];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic               wr_en, rd_en;

  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    wr_en  = wr && !full;
    rd_en  = rd && !empty;
    wptr_d = wr_en ? wptr_q + PW'(1) : wptr_q;
    rptr_d = rd_en ? rptr_q + PW'(1) : rptr_q;
  end

  assign out = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not cleared; pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wptr_q[AW-1:0]] <= in;
  end
endmodule

// File: rtl/ofifo.sv
// Output FIFO bank under the MAC array: per-column skewed capture, column-aligned row pop.
module ofifo import ofifo_pkg::*; #(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = 16
) (
  input logic    clk,
  input logic    reset,
  ofifo_if.slave bus
);
  logic [col*psum_bw-1:0] head_row;
  logic [col*psum_bw-1:0] out_q, out_d;
  logic [col-1:0]         empty, full;
  logic                   overflow_q, overflow_d;
  logic                   valid, rd_acc;

  assign valid  = ~|empty;
  assign rd_acc = bus.rd && valid;

  for (genvar i = 0; i < col; i++) begin : g_lane
    fifo_lane #(.psum_bw(psum_bw), .depth(depth)) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (bus.wr[i]),
      .rd    (rd_acc),
      .in    (bus.in[i*psum_bw +: psum_bw]),
      .out   (head_row[i*psum_bw +: psum_bw]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  always_comb begin
    out_d      = rd_acc ? head_row : out_q;
    overflow_d = overflow_q | (|(bus.wr & full));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.o_valid    = valid;
  assign bus.o_full     = |full;
  assign bus.o_ready    = ~(|full);
  assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_ofifo.sv
// Directed bench for ofifo with a queue-based reference model compared on every cycle.
module tb_ofifo;
  localparam int NCOL  = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int W     = NCOL * BW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ofifo_if #(.col(NCOL), .psum_bw(BW)) bus ();

  ofifo #(.col(NCOL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] row(input int base);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NCOL; i++) r[i*BW +: BW] = BW'(base + i);
    return r;
  endfunction

  // Reference model: one queue per lane
  logic [BW-1:0] mq [NCOL][$];
  logic [W-1:0]  m_out = '0;
  bit            m_ovf = 1'b0;
  bit            m_valid, m_fullv;
  bit            lane_full [NCOL];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCOL; i++) mq[i].delete();
      m_out = '0;
      m_ovf = 1'b0;
    end else begin
      m_valid = 1'b1;
      for (int i = 0; i < NCOL; i++) begin
        if (mq[i].size() == 0) m_valid = 1'b0;
        lane_full[i] = (mq[i].size() == DEPTH);
      end
      if (bus.rd && m_valid)
        for (int i = 0; i < NCOL; i++) m_out[i*BW +: BW] = mq[i].pop_front();
      for (int i = 0; i < NCOL; i++)
        if (bus.wr[i]) begin
          if (lane_full[i]) m_ovf = 1'b1;
          else mq[i].push_back(bus.in[i*BW +: BW]);
        end
    end
  end

  bit e_valid, e_full;
  always @(negedge clk) begin
    if (chk_en) begin
      e_valid = 1'b1;
      e_full  = 1'b0;
      for (int i = 0; i < NCOL; i++) begin
        if (mq[i].size() == 0) e_valid = 1'b0;
        if (mq[i].size() == DEPTH) e_full = 1'b1;
      end
      chk("model_out", bus.out, m_out);
      chk("model_valid", W'(bus.o_valid), W'(e_valid));
      chk("model_full", W'(bus.o_full), W'(e_full));
      chk("model_ready", W'(bus.o_ready), W'(!e_full));
      chk("model_overflow", W'(bus.o_overflow), W'(m_ovf));
    end
  end

  task automatic step(input logic [NCOL-1:0] w, input logic r, input logic [W-1:0] d);
    bus.wr = w;
    bus.rd = r;
    bus.in = d;
    @(posedge clk);
    #1;
    bus.wr = '0;
    bus.rd = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    bus.wr = '1;
    bus.rd = 1'b1;
    bus.in = row(16'h0abc);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
  endtask

  initial begin
    logic [NCOL-1:0] w;
    logic [W-1:0]    d, e;
    int              r;

    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out", bus.out, '0);
    chk("rst_valid", W'(bus.o_valid), W'(0));
    chk("rst_full", W'(bus.o_full), W'(0));
    chk("rst_ready", W'(bus.o_ready), W'(1));
    chk("rst_overflow", W'(bus.o_overflow), W'(0));

    // Skewed fill: lane i gets 16*r+i at cycle r+i
    for (int c = 0; c <= 10; c++) begin
      w = '0;
      d = '0;
      for (int i = 0; i < NCOL; i++) begin
        r = c - i;
        if (r >= 0 && r <= 3) begin
          w[i] = 1'b1;
          d[i*BW +: BW] = BW'(16 * r + i);
        end
      end
      step(w, 1'b0, d);
      if (c == 6) chk("skew_valid_before_lane7", W'(bus.o_valid), W'(0));
      if (c == 7) chk("skew_valid_after_lane7", W'(bus.o_valid), W'(1));
    end
    for (int k = 0; k < 4; k++) begin
      step('0, 1'b1, '0);
      chk("skew_row", bus.out, row(16 * k));
    end
    chk("skew_drained_valid", W'(bus.o_valid), W'(0));

    // Fill lane 0 to capacity, then overflow it
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      d = '0;
      d[BW-1:0] = BW'(100 + k);
      step(8'h01, 1'b0, d);
    end
    chk("full_full", W'(bus.o_full), W'(1));
    chk("full_ready", W'(bus.o_ready), W'(0));
    chk("full_valid", W'(bus.o_valid), W'(0));
    chk("full_no_ovf_yet", W'(bus.o_overflow), W'(0));
    d = '0;
    d[BW-1:0] = BW'(999);
    step(8'h01, 1'b0, d);
    chk("full_ovf_set", W'(bus.o_overflow), W'(1));
    for (int k = 0; k < 2; k++) begin
      step(8'hfe, 1'b0, row(16'h70));
      step('0, 1'b1, '0);
      e = row(16'h70);
      e[BW-1:0] = BW'(100 + k);
      chk("full_data_intact", bus.out, e);
    end
    chk("full_ovf_sticky", W'(bus.o_overflow), W'(1));

    // Read while lane 3 is empty
    do_reset();
    chk("ovf_cleared_by_reset", W'(bus.o_overflow), W'(0));
    step('1, 1'b0, row(16'h50));
    step('0, 1'b1, '0);
    chk("empty_rd_first", bus.out, row(16'h50));
    step(8'hf7, 1'b0, row(16'h60));
    step('0, 1'b1, '0);
    chk("empty_rd_out_held", bus.out, row(16'h50));
    chk("empty_rd_valid", W'(bus.o_valid), W'(0));
    step(8'h08, 1'b0, row(16'h60));
    step('0, 1'b1, '0);
    chk("empty_rd_next_row", bus.out, row(16'h60));
    chk("empty_rd_after_valid", W'(bus.o_valid), W'(0));

    // Simultaneous write and pop across pointer wrap
    do_reset();
    step('1, 1'b0, row(16'h200));
    for (int k = 1; k <= 40; k++) begin
      step('1, 1'b1, row(16'h200 + 16 * k));
      chk("stream_row", bus.out, row(16'h200 + 16 * (k - 1)));
    end
    chk("stream_valid", W'(bus.o_valid), W'(1));
    chk("stream_ovf", W'(bus.o_overflow), W'(0));

    // Reset with 5 rows buffered
    do_reset();
    for (int k = 0; k < 5; k++) step('1, 1'b0, row(16'h300 + 16 * k));
    do_reset();
    chk("midrst_valid", W'(bus.o_valid), W'(0));
    chk("midrst_out", bus.out, '0);
    step('1, 1'b0, row(16'h400));
    step('0, 1'b1, '0);
    chk("midrst_new_row", bus.out, row(16'h400));
    chk("midrst_drained", W'(bus.o_valid), W'(0));

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/ofifo.md
# ofifo

Output FIFO bank that sits directly below the bottom row of the weight-stationary MAC array. It captures one partial sum per column, at whatever cycle that column's result emerges, despite the diagonal skew of the array. It then presents a column-aligned row of `col` partial sums to the downstream accumulator/SFU through a single read strobe. Each column is an independent circular buffer; reads pop all columns together.

## Interface

Parameters:
- `col`, 8, number of array columns (one FIFO lane each)
- `psum_bw`, 16, partial-sum width per column (matches MAC tile `out_s`)
- `depth`, 16, entries per lane; power of two, at least 2

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `in`  in  col*psum_bw  column i psum at bits [i*psum_bw +: psum_bw]
- `wr`  in  col  per-column write strobe (bottom-row valid, skewed per column)
- `rd`  in  1  pop one aligned row
- `out`  out  col*psum_bw  registered aligned row, same lane packing as `in`
- `o_valid`  out  1  every lane non-empty
- `o_full`  out  1  any lane full
- `o_ready`  out  1  equals ~o_full
- `o_overflow`  out  1  sticky: a write hit a full lane

## Operation

- Per lane: storage of `depth` x `psum_bw`, plus write and read pointers of log2(depth)+1 bits.
  - Lane is empty when the pointers are equal.
  - Lane is full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally at 2*depth.
- Write, lane i: when `wr[i]` and lane i is not full, store `in[i]` at wptr_i and increment wptr_i.
  - If lane i is full, the write is dropped, wptr_i is unchanged and `o_overflow` is set.
  - Fullness is evaluated on pre-edge state, so a same-cycle pop does not make room.
- Read: accepted when `rd && o_valid`.
  - Each lane's head goes to `out`, and all rptrs increment together.
  - When `rd` arrives with `o_valid` low, it is ignored: `out` holds and no pointer moves.
- A write and an accepted read on the same lane in the same cycle are both performed. The lane count is unchanged.
- Flags (`o_valid`, `o_full`, `o_ready`) are combinational from the pointers.
- `o_overflow` clears only on reset.
- Reset values:
  - pointers 0, `out` 0, `o_overflow` 0
  - hence `o_valid` 0, `o_full` 0, `o_ready` 1
  - storage array is not reset
- Reset asserted mid-stream discards all contents at that edge. A `wr` or `rd` in the reset cycle is ignored.
- There is no arithmetic on data; values pass bit-exact.

## Timing

- Write-to-visible: an entry written at edge N contributes to `o_valid` from N+1. A row whose last lane is written at edge N can be popped at edge N+1.
- Read latency: `rd` accepted at edge N puts the row on `out` after edge N; `out` is valid from N to N+1 onward until the next accepted read.
- Throughput: one row per cycle while `o_valid` holds; one write per lane per cycle.
- Skew tolerance: lanes may lead each other by up to `depth`-1 entries without loss.

## Structure

- Shared package holds:
  - `PSUM_BW` and `COL` defaults, common with the MAC array
  - pointer width as a function: clog2(depth)+1
- Natural sub-module: `fifo_lane` (single-column circular buffer, with ports wr, rd, in, out, empty, full), instantiated `col` times via generate.
  - `ofifo` holds the AND of empties, the OR of fulls, the overflow flag and the `out` register.

## Test plan

- Reset, then idle: `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1, `o_overflow`=0.
- Skewed fill: lane i is written value 16*r+i at cycle r+i for r=0..3.
  - `o_valid` rises only after lane 7's first write.
  - Four accepted `rd` yield rows {16r+7,...,16r+0} in order, then `o_valid`=0.
- Full: write 16 entries to lane 0 only → `o_full`=1, `o_ready`=0, `o_valid`=0. A 17th write sets `o_overflow`, and the earlier data are intact on later pops.
- Read while empty: `rd`=1 with lane 3 empty → `out` unchanged and no pointer moves. A subsequent fill gives the correct first row.
- Simultaneous write and read on every lane for 40 cycles at occupancy 1 → rows emerge in order across pointer wrap with no loss, `o_overflow`=0.
- Reset mid-stream with 5 rows buffered → next cycle `o_valid`=0 and `out`=0. A new single row reads back correctly.
